// File: rtl/calc_alu_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | calc_alu_seq: sequential sign-magnitude add/sub/multiply unit sharing one |
// | adder. Optional macro CALC_SAT_EN selects saturation on overflow.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module calc_alu_seq #(
  parameter int MAG_W = 15
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [MAG_W:0]   a_in,
  input  logic [MAG_W:0]   b_in,
  output logic             busy,
  output logic             done,
  output logic [MAG_W:0]   result,
  output logic             ovf,
  output logic             err
);

  localparam int           c_DW     = 2 * MAG_W;
  localparam int           c_CW     = $clog2(MAG_W + 1);
  localparam logic [2:0]   c_OP_ADD = 3'b010;
  localparam logic [2:0]   c_OP_SUB = 3'b011;
  localparam logic [2:0]   c_OP_MUL = 3'b100;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(MAG_W - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  state_t                r_state;
  logic [2:0]            r_op;
  logic                  r_sa;
  logic                  r_sb;
  logic [MAG_W-1:0]      r_ma;
  logic [MAG_W-1:0]      r_mb;
  logic [c_DW-1:0]       r_mcand;
  logic [c_DW-1:0]       r_acc;
  logic [c_CW-1:0]       r_cnt;

  logic                  w_sb_eff;
  logic                  w_a_ge;
  logic                  w_diff;
  logic [MAG_W-1:0]      w_big;
  logic [MAG_W-1:0]      w_small;
  logic [c_DW-1:0]       w_x;
  logic [c_DW-1:0]       w_y;
  logic                  w_cin;
  logic [c_DW-1:0]       w_mag;
  logic                  w_sign;
  logic                  w_ovf;
  logic [MAG_W-1:0]      w_mag_out;
  logic [MAG_W:0]        w_result;

  // Subtract is an add with B's sign flipped; unlike signs subtract the
  // smaller magnitude from the larger so the difference is never negative.
  assign w_sb_eff = r_sb ^ (r_op == c_OP_SUB);
  assign w_a_ge   = (r_ma >= r_mb);
  assign w_diff   = r_sa ^ w_sb_eff;
  assign w_big    = w_a_ge ? r_ma : r_mb;
  assign w_small  = w_a_ge ? r_mb : r_ma;

  always_comb begin
    w_x   = '0;
    w_y   = '0;
    w_cin = 1'b0;
    if (r_op == c_OP_MUL) begin
      w_x = r_acc;
      w_y = r_mb[0] ? r_mcand : '0;
    end else begin
      w_x   = c_DW'(w_big);
      w_y   = w_diff ? ~(c_DW'(w_small)) : c_DW'(w_small);
      w_cin = w_diff;
    end
  end

  // The single shared adder.
  assign w_mag  = w_x + w_y + c_DW'(w_cin);
  assign w_sign = (r_op == c_OP_MUL) ? (r_sa ^ r_sb) : (w_a_ge ? r_sa : w_sb_eff);
  assign w_ovf  = |w_mag[c_DW-1:MAG_W];

`ifdef CALC_SAT_EN
  assign w_mag_out = w_ovf ? {MAG_W{1'b1}} : w_mag[MAG_W-1:0];
`else
  assign w_mag_out = w_mag[MAG_W-1:0];
`endif

  // A zero magnitude is always reported as positive zero.
  assign w_result = (w_mag_out == '0) ? '0 : {w_sign, w_mag_out};

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_ma    <= '0;
      r_mb    <= '0;
      r_mcand <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      ovf     <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_op    <= op;
            r_sa    <= a_in[MAG_W];
            r_ma    <= a_in[MAG_W-1:0];
            r_sb    <= b_in[MAG_W];
            r_mb    <= b_in[MAG_W-1:0];
            r_mcand <= c_DW'(a_in[MAG_W-1:0]);
            r_acc   <= '0;
            r_cnt   <= '0;
            ovf     <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b1;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          if (r_op == c_OP_MUL) begin
            // Shift-and-add, one multiplier bit per cycle, LSB first.
            r_acc   <= w_mag;
            r_mcand <= r_mcand << 1;
            r_mb    <= r_mb >> 1;
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt == c_LAST) begin
              result  <= w_result;
              ovf     <= w_ovf;
              done    <= 1'b1;
              r_state <= DONE;
            end
          end else if ((r_op == c_OP_ADD) || (r_op == c_OP_SUB)) begin
            result  <= w_result;
            ovf     <= w_ovf;
            done    <= 1'b1;
            r_state <= DONE;
          end else begin
            result  <= '0;
            ovf     <= 1'b0;
            err     <= 1'b1;
            done    <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/calc_alu_seq.md
CALC_ALU_SEQ -- requirements
Module: calc_alu_seq

Interface
REQ-001 SHALL have parameter MAG_W, default 15, meaning the operand/result magnitude width; the word width is MAG_W+1, sign in the MSB.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-003 SHALL have port nRST, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request an operation; sampled only in IDLE.
REQ-005 SHALL have port op, input, 3 bits: 3'b010 add, 3'b011 subtract (a-b), 3'b100 multiply; any other code is illegal.
REQ-006 SHALL have port a_in, input, 16 bits: sign-magnitude operand A.
REQ-007 SHALL have port b_in, input, 16 bits: sign-magnitude operand B.
REQ-008 SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until done deasserts.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port result, output, 16 bits: sign-magnitude result, held until the next accepted start.
REQ-011 SHALL have port ovf, output, 1 bit: magnitude exceeded 2^MAG_W-1; valid with done, held like result.
REQ-012 SHALL have port err, output, 1 bit: illegal op; valid with done, held like result.

Function
REQ-013 SHALL implement states IDLE, EXEC, DONE.
REQ-014 IDLE with start=1 at edge k SHALL capture op/a_in/b_in, clear ovf and err, and go to EXEC; busy=1 after edge k.
REQ-015 Add, subtract and illegal op SHALL occupy EXEC for 1 cycle: DONE after edge k+1, done=1 for that cycle, IDLE after edge k+2.
REQ-016 Multiply SHALL use one shared adder, one multiplier magnitude bit per cycle (LSB first), with MAG_W EXEC cycles: DONE after edge k+MAG_W.
REQ-017 Add/sub SHALL be performed on magnitudes with sign compare (subtract = add with B sign inverted); result sign is the sign of the larger magnitude.
REQ-018 Multiply sign SHALL be sign(A) XOR sign(B); the magnitude accumulator is 2*MAG_W bits wide.
REQ-019 Any zero magnitude result SHALL be output as 16'h0000 (never negative zero); input 16'h8000 is treated as zero.
REQ-020 Illegal op SHALL give result=16'h0000, err=1, ovf=0.
REQ-021 start while busy SHALL be ignored; operands SHALL NOT change mid-operation.
REQ-022 start held high through DONE SHALL NOT be accepted until the cycle the FSM is back in IDLE (back-to-back gap is 1 idle cycle minimum).
REQ-023 done SHALL never be high for two consecutive cycles.

Reset
REQ-024 nRST low SHALL immediately force IDLE, busy=0, done=0, result=16'h0000, ovf=0, err=0, and clear the multiply counter/accumulator.
REQ-025 Reset during EXEC SHALL abort the operation with no done pulse; the first start after release is accepted normally.

Configuration
REQ-026 Macro CALC_SAT_EN defined: on overflow, result magnitude SHALL saturate to 2^MAG_W-1 with the computed sign, and ovf=1.
REQ-027 CALC_SAT_EN undefined: on overflow, result magnitude SHALL be the low MAG_W bits (wrap) with the computed sign, zero-normalized per REQ-019, and ovf=1.

Verification
REQ-028 add: A=0x8019 (-25), B=0x800F (-15), start at edge k -> done after edge k+1, result 0x8028, ovf=0.
REQ-029 sub: A=0x0003, B=0x0005 -> result 0x8002; add: A=0x800A, B=0x000A -> result 0x0000 (not 0x8000).
REQ-030 mul: A=0x800C (-12), B=0x0BB8 (3000) -> done after edge k+15, ovf=1; result 0xFFFF with CALC_SAT_EN, 0x8CA0 without.
REQ-031 mul: A=0x0080, B=0x0100 -> ovf=1, result 0x7FFF (CALC_SAT_EN) or 0x0000 (wrap); op=3'b111 -> err=1, result 0x0000.
REQ-032 start pulsed during multiply EXEC -> ignored, exactly one done; nRST low at k+7 of a multiply -> busy/done 0 immediately, no done, next start completes normally.
